// File: rtl/sr_pulse_driver.sv
// sr_pulse_driver: sequences set/clear pulses into an external S-R latch with
// active-low set, reset and clear inputs, then waits for the latch output to
// confirm the new state.
//
// Parameters
//   PULSE_W : width of the active-low s_n/r_n pulse in clk cycles (1..15)
//   SETTLE  : idle cycles between the end of the pulse and checking q (0..15)
//   TIMEOUT : CHECK cycles allowed before giving up with err (1..255)
//
// Ports
//   clk      : single clock, rising edge
//   reset    : synchronous, active-high reset
//   req_set  : one-cycle request to drive the latch to q=1
//   req_clr  : one-cycle request to drive the latch to q=0
//   s_n      : active-low latch set (registered)
//   r_n      : active-low latch reset (registered)
//   clr_n    : active-low latch clear, low during reset plus one cycle
//   q_in     : asynchronous latch output
//   q_sync   : q_in after a two-flop synchronizer
//   busy     : high while a sequence is in progress
//   done     : one-cycle pulse when the latch confirms the target state
//   err      : one-cycle pulse on a conflicting request or a timeout
module sr_pulse_driver #(
    parameter int unsigned PULSE_W = 4,
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic req_set,
    input  logic req_clr,
    output logic s_n,
    output logic r_n,
    output logic clr_n,
    input  logic q_in,
    output logic q_sync,
    output logic busy,
    output logic done,
    output logic err
);

    typedef enum logic [1:0] {StIdle, StPulse, StSettle, StCheck} state_e;

    // Terminal counter values for each timed state; the counter starts at 0 on entry.
    localparam logic [7:0] PulseLast   = 8'(PULSE_W - 1);
    localparam logic [7:0] SettleLast  = 8'((SETTLE > 0) ? SETTLE - 1 : 32'd0);
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);
    localparam bit         SkipSettle  = (SETTLE == 0);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       target_q, target_d;
    logic       sync1_q, q_sync_q;
    logic       s_n_q, s_n_d;
    logic       r_n_q, r_n_d;
    logic       clr_n_q;
    logic       done_q, done_d;
    logic       err_q, err_d;

    // State register, plus every registered output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= 8'd0;
            target_q <= 1'b0;
            sync1_q  <= 1'b0;
            q_sync_q <= 1'b0;
            s_n_q    <= 1'b1;
            r_n_q    <= 1'b1;
            clr_n_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            sync1_q  <= q_in;
            q_sync_q <= sync1_q;
            s_n_q    <= s_n_d;
            r_n_q    <= r_n_d;
            clr_n_q  <= 1'b1;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                // clr_n_q low marks the cycle reset fell: the latch is still being
                // cleared, so requests in that cycle are dropped.
                if (clr_n_q) begin
                    if (req_set && req_clr) begin
                        err_d = 1'b1;
                    end else if (req_set || req_clr) begin
                        target_d = req_set;
                        state_d  = StPulse;
                    end
                end
            end
            StPulse: begin
                if (cnt_q == PulseLast) begin
                    state_d = SkipSettle ? StCheck : StSettle;
                end
            end
            StSettle: begin
                if (cnt_q == SettleLast) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (q_sync_q == target_q) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (cnt_q == TimeoutLast) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // One shared counter: cleared on every state change, saturating otherwise.
        if (state_d != state_q) begin
            cnt_d = 8'd0;
        end else if (cnt_q == 8'hff) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Output logic. Pulse lines are computed from the next state and registered,
    // so the pulse starts the cycle after acceptance and only one line can be low.
    always_comb begin
        s_n_d = ~((state_d == StPulse) && target_d);
        r_n_d = ~((state_d == StPulse) && !target_d);
        busy  = (state_q != StIdle);
    end

    assign s_n    = s_n_q;
    assign r_n    = r_n_q;
    assign clr_n  = clr_n_q;
    assign q_sync = q_sync_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_sr_pulse_driver.sv
// tb_sr_pulse_driver: directed bench for sr_pulse_driver with a behavioural
// S-R latch (one-cycle q delay) and a scoreboard of expected transaction results.
module tb_sr_pulse_driver;

    localparam int unsigned PULSE_W = 4;
    localparam int unsigned SETTLE  = 2;
    localparam int unsigned TIMEOUT = 15;

    logic clk     = 1'b0;
    logic reset   = 1'b1;
    logic req_set = 1'b0;
    logic req_clr = 1'b0;
    logic q_lat   = 1'b0;
    logic stuck   = 1'b0;
    logic q_in;
    logic s_n, r_n, clr_n, q_sync, busy, done, err;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct packed {
        logic       done;
        logic       err;
        logic [7:0] lat_min;
        logic [7:0] lat_max;
        logic [7:0] s_low;
        logic [7:0] r_low;
        logic [7:0] first_low;
        logic       q;
    } exp_t;

    exp_t  sb[$];
    string sb_tag[$];

    sr_pulse_driver #(
        .PULSE_W (PULSE_W),
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req_set (req_set),
        .req_clr (req_clr),
        .s_n     (s_n),
        .r_n     (r_n),
        .clr_n   (clr_n),
        .q_in    (q_in),
        .q_sync  (q_sync),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Latch model: clear dominates, then set, then reset; q follows one cycle later.
    always @(posedge clk) begin
        if (!clr_n)    q_lat <= 1'b0;
        else if (!s_n) q_lat <= 1'b1;
        else if (!r_n) q_lat <= 1'b0;
    end
    assign q_in = stuck ? 1'b0 : q_lat;

    // Invariants watched on every falling edge.
    always @(negedge clk) begin
        if (cyc > 0) begin
            assert (!(!s_n && !r_n)) else begin
                n_err++;
                $error("FAIL sr_overlap: observed s_n=%b r_n=%b, required not both 0", s_n, r_n);
            end
            assert (!(done && err)) else begin
                n_err++;
                $error("FAIL done_err_overlap: observed done=%b err=%b, required not both 1",
                       done, err);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, required %0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        n_cmp++;
        assert (obs >= lo && obs <= hi) else begin
            n_err++;
            $error("FAIL %s: observed %0d, required %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic expect_txn(input string tag, input logic e_done, input logic e_err,
                              input int lo, input int hi, input int s_low, input int r_low,
                              input int first, input logic e_q);
        exp_t e;
        e.done      = e_done;
        e.err       = e_err;
        e.lat_min   = 8'(lo);
        e.lat_max   = 8'(hi);
        e.s_low     = 8'(s_low);
        e.r_low     = 8'(r_low);
        e.first_low = 8'(first);
        e.q         = e_q;
        sb.push_back(e);
        sb_tag.push_back(tag);
    endtask

    // Watch the DUT after a request until done/err (bounded), then score it.
    // clr_at > 0 injects a req_clr during that cycle of the sequence.
    task automatic observe(input int clr_at);
        int    lat;
        int    s_low;
        int    r_low;
        int    first;
        logic  got_done;
        logic  got_err;
        exp_t  e;
        string tag;
        lat = -1; s_low = 0; r_low = 0; first = 0; got_done = 1'b0; got_err = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            req_set = 1'b0;
            req_clr = 1'b0;
            if (!s_n) begin s_low++; if (first == 0) first = k; end
            if (!r_n) begin r_low++; if (first == 0) first = k; end
            if (done || err) begin
                lat = k; got_done = done; got_err = err;
                break;
            end
            if (k == clr_at) req_clr = 1'b1;
        end
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
            return;
        end
        e   = sb.pop_front();
        tag = sb_tag.pop_front();
        check_range({tag, "_latency"}, lat, int'(e.lat_min), int'(e.lat_max));
        check({tag, "_done"}, 32'(got_done), 32'(e.done));
        check({tag, "_err"}, 32'(got_err), 32'(e.err));
        check({tag, "_s_low_cycles"}, s_low, 32'(e.s_low));
        check({tag, "_r_low_cycles"}, r_low, 32'(e.r_low));
        check({tag, "_first_low_cycle"}, first, 32'(e.first_low));
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_q_sync"}, 32'(q_sync), 32'(e.q));
    endtask

    localparam int MinDone = 1 + PULSE_W + SETTLE + 1;

    initial begin
        int stray;

        // Reset state.
        tick(); tick(); tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_s_n", 32'(s_n), 32'd1);
        check("rst_r_n", 32'(r_n), 32'd1);
        check("rst_clr_n", 32'(clr_n), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_q_sync", 32'(q_sync), 32'd0);

        // Request in the cycle reset falls is dropped.
        reset   = 1'b0;
        req_set = 1'b1;
        tick();
        check("fall_clr_n", 32'(clr_n), 32'd1);
        check("fall_req_ignored_busy", 32'(busy), 32'd0);
        check("fall_req_ignored_s_n", 32'(s_n), 32'd1);

        // Set path: s_n low cycles 1..PULSE_W, done by cycle 10.
        req_set = 1'b1;
        expect_txn("set", 1'b1, 1'b0, MinDone, 10, PULSE_W, 0, 1, 1'b1);
        observe(0);

        // Clear after set.
        req_clr = 1'b1;
        expect_txn("clr", 1'b1, 1'b0, MinDone, 10, 0, PULSE_W, 1, 1'b0);
        observe(0);

        // Conflicting request: err next cycle, no pulse.
        req_set = 1'b1;
        req_clr = 1'b1;
        expect_txn("conflict", 1'b0, 1'b1, 1, 1, 0, 0, 0, 1'b0);
        observe(0);
        tick();
        check("conflict_err_one_cycle", 32'(err), 32'd0);
        check("conflict_busy", 32'(busy), 32'd0);

        // Set with a req_clr during PULSE that must be ignored.
        req_set = 1'b1;
        expect_txn("set_ignore_clr", 1'b1, 1'b0, MinDone, 10, PULSE_W, 0, 1, 1'b1);
        observe(2);

        // Timeout: q held at 0; err exactly TIMEOUT cycles after CHECK entry.
        stuck   = 1'b1;
        req_set = 1'b1;
        expect_txn("timeout", 1'b0, 1'b1, 1 + PULSE_W + SETTLE + TIMEOUT,
                   1 + PULSE_W + SETTLE + TIMEOUT, PULSE_W, 0, 1, 1'b0);
        observe(0);
        stuck = 1'b0;
        tick(); tick(); tick();
        check("release_q_sync", 32'(q_sync), 32'd1);

        // Reset asserted during SETTLE aborts with no done/err.
        req_clr = 1'b1;
        for (int k = 0; k < 1 + PULSE_W; k++) begin
            tick();
            req_clr = 1'b0;
        end
        check("settle_busy", 32'(busy), 32'd1);
        check("settle_r_n", 32'(r_n), 32'd1);
        reset = 1'b1;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_clr_n", 32'(clr_n), 32'd0);
        check("abort_s_n", 32'(s_n), 32'd1);
        check("abort_r_n", 32'(r_n), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        tick();
        reset = 1'b0;
        stray = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done || err || busy) stray++;
        end
        check("abort_no_stray_activity", stray, 32'd0);
        check("abort_clr_n_released", 32'(clr_n), 32'd1);
        check("abort_q_sync_cleared", 32'(q_sync), 32'd0);
        check("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
